// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier: product = quo * {1'b0, divisior} + rem.
// Fixed 17-edge latency from start acceptance to the done pulse.
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] quo,
  input  logic [14:0] divisior,
  input  logic [15:0] rem,
  output logic [31:0] product,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [15:0] mcand_q,   mcand_d;
  logic [15:0] mplier_q,  mplier_d;
  logic [15:0] rem_q,     rem_d;
  logic [16:0] acc_q,     acc_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic [31:0] product_q, product_d;
  logic        ovf_q,     ovf_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  logic [16:0] sum_s;
  logic [16:0] step_s;
  logic [31:0] final_s;

  // Next-state and datapath logic for the IDLE/RUN/ADD/DONE sequence.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    // acc_q[16] is always 0 between iterations, so the 17-bit sum cannot overflow.
    sum_s   = acc_q + {1'b0, mcand_q};
    step_s  = mplier_q[0] ? sum_s : acc_q;
    final_s = {acc_q[15:0], mplier_q} + {16'd0, rem_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = quo;
          mplier_d = {1'b0, divisior};
          rem_d    = rem;
          acc_d    = 17'd0;
          cnt_d    = 5'd16;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = {1'b0, step_s[16:1]};
        mplier_d = {step_s[0], mplier_q[15:1]};
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ADD;
        end else begin
          state_d = RUN;
        end
      end
      ADD: begin
        product_d = final_s;
        ovf_d     = |final_s[31:16];
        done_d    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == ADD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      rem_q     <= 16'd0;
      acc_q     <= 17'd0;
      cnt_q     <= 5'd0;
      product_q <= 32'd0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
